// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer for the shared 16x16 MAC: clear, stream, drain, capture.
// Optional abort input is compiled in when MAC_SEQ_ABORT_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; len sampled with start
// CLEAR   | one cycle of mac_clr with zero operands
// RUN     | in_ready high; accepted pairs go to the MAC, gaps send zeros
// DRAIN   | zeros for MAC_LAT cycles while the last product settles
// DONE    | one-cycle done pulse with the captured result
module mac_seq_ctrl #(
  parameter int DW      = 16,
  parameter int ACCW    = 36,
  parameter int LW      = 8,
  parameter int MAC_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [LW-1:0]   len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic [DW-1:0]   mac_a,
  output logic [DW-1:0]   mac_b,
  output logic            mac_clr,
  input  logic [ACCW-1:0] mac_out,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] result
`ifdef MAC_SEQ_ABORT_EN
  ,
  input  logic            abort
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(MAC_LAT - 1);

  logic [2:0]     state;
  logic [2:0]     state_nx;
  logic [LW-1:0]  len_q;
  logic [LW-1:0]  count;
  logic [DCW-1:0] drain_cnt;
  logic           hs;
  logic           last_hs;
  logic           drain_last;
  logic           abort_hit;

  assign hs         = in_valid & in_ready;
  assign last_hs    = hs && (count == (len_q - LW'(1)));
  assign drain_last = (state == S_DRAIN) && (drain_cnt == '0);

`ifdef MAC_SEQ_ABORT_EN
  assign abort_hit = abort &&
                     ((state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (len == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: state_nx = S_RUN;
      S_RUN:   if (last_hs) state_nx = S_DRAIN;
      S_DRAIN: if (drain_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort_hit) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      count     <= '0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      result    <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == S_RUN);
      busy     <= (state_nx != S_IDLE);
      done     <= (state_nx == S_DONE);
      mac_clr  <= (state_nx == S_CLEAR) || abort_hit;

      // any cycle without an accepted pair feeds the MAC zeros
      if (hs && !abort_hit) begin
        mac_a <= in_a;
        mac_b <= in_b;
      end else begin
        mac_a <= '0;
        mac_b <= '0;
      end

      if ((state == S_IDLE) && start) len_q <= len;

      if (state == S_CLEAR) count <= '0;
      else if (hs)          count <= count + LW'(1);

      if ((state == S_RUN) && (state_nx == S_DRAIN)) drain_cnt <= DRAIN_INIT;
      else if (state == S_DRAIN)                     drain_cnt <= drain_cnt - DCW'(1);

      if (drain_last && !abort_hit)
        result <= mac_out;
      else if ((state == S_IDLE) && start && (len == '0))
        result <= '0;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: behavioural MAC, arithmetic dot-product
// reference, directed cases from the feature list and randomized jobs.
module tb_mac_seq_ctrl;
  localparam int DW      = 16;
  localparam int ACCW    = 36;
  localparam int LW      = 8;
  localparam int MAC_LAT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [LW-1:0]   len = '0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_a = '0;
  logic [DW-1:0]   in_b = '0;
  logic            in_ready;
  logic [DW-1:0]   mac_a;
  logic [DW-1:0]   mac_b;
  logic            mac_clr;
  logic [ACCW-1:0] mac_out;
  logic            busy;
  logic            done;
  logic [ACCW-1:0] result;
`ifdef MAC_SEQ_ABORT_EN
  logic            abort = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] ja [256];
  logic [DW-1:0] jb [256];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.DW(DW), .ACCW(ACCW), .LW(LW), .MAC_LAT(MAC_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_clr  (mac_clr),
    .mac_out  (mac_out),
    .busy     (busy),
    .done     (done),
    .result   (result)
`ifdef MAC_SEQ_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  // accumulator: a product loaded at one edge is in mac_out after the next edge
  logic [ACCW-1:0] acc = '0;
  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else         acc <= acc + (ACCW'(mac_a) * ACCW'(mac_b));
  end
  assign mac_out = acc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_mac_ab"}, {mac_a, mac_b}, 0);
    check_val({tag, "_mac_clr"}, mac_clr, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_result"}, result, 0);
  endtask

  // one job of n pairs from ja/jb; gap_pct random bubbles, fixed_gap forced bubbles after pair 1
  task automatic run_job(input int n, input int gap_pct, input int fixed_gap, input bit noisy);
    logic [63:0]     sum;
    logic [ACCW-1:0] exp_res;
    logic [DW-1:0]   la, lb;
    int  idx, bub, forced, cyc, clr_seen;
    bit  fin, was_hs, was_gap;
    sum = 0;
    for (int i = 0; i < n; i++) sum += 64'(ja[i]) * 64'(jb[i]);
    exp_res = sum[ACCW-1:0];
    la = '0; lb = '0;
    @(negedge clk);
    start = 1'b1; len = LW'(n); in_valid = 1'b0;
    idx = 0; bub = 0; forced = 0; cyc = 0; clr_seen = 0;
    fin = 0; was_hs = 0; was_gap = 0;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = noisy ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (noisy) len = LW'($urandom);
      if (mac_clr) clr_seen++;
      if (was_hs) begin
        check_val("mac_a_load", mac_a, la);
        check_val("mac_b_load", mac_b, lb);
      end
      if (was_gap) check_val("gap_zero", {mac_a, mac_b}, 0);
      was_hs = 0; was_gap = 0;
      if (done) begin
        fin = 1;
        check_val("latency", cyc, (n == 0) ? 1 : n + MAC_LAT + 2 + bub);
        check_val("result", result, exp_res);
        check_val("busy_in_done", busy, 1);
        check_val("mac_clr_count", clr_seen, (n == 0) ? 0 : 1);
        check_val("pairs_taken", idx, n);
        in_valid = 1'b0;
        start = 1'b1;
      end else if (in_ready && idx < n) begin
        if ((idx == 1 && forced < fixed_gap) || ($urandom_range(0, 99) < gap_pct)) begin
          if (idx == 1 && forced < fixed_gap) forced++;
          in_valid = 1'b0; in_a = DW'($urandom); in_b = DW'($urandom);
          bub++; was_gap = 1;
        end else begin
          in_valid = 1'b1; in_a = ja[idx]; in_b = jb[idx];
          la = ja[idx]; lb = jb[idx];
          idx++; was_hs = 1;
        end
      end else begin
        in_valid = noisy ? 1'($urandom) : 1'b0;
        in_a = DW'($urandom); in_b = DW'($urandom);
      end
    end
    if (!fin) check_val("done_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check_val("busy_after_done", busy, 0);
    check_val("done_single_pulse", done, 0);
    @(negedge clk);
    check_val("start_in_done_ignored", busy, 0);
    check_val("result_hold", result, exp_res);
  endtask

  task automatic load_68();
    ja[0] = 2; jb[0] = 3;
    ja[1] = 4; jb[1] = 5;
    ja[2] = 6; jb[2] = 7;
  endtask

  // start a 3-pair job and stop after the first pair is accepted
  task automatic start_one_pair();
    load_68();
    @(negedge clk); start = 1'b1; len = 3;
    @(negedge clk); start = 1'b0;
    check_val("clear_pulse", mac_clr, 1);
    @(negedge clk);
    check_val("run_ready", in_ready, 1);
    in_valid = 1'b1; in_a = ja[0]; in_b = jb[0];
    @(negedge clk);
    in_valid = 1'b0;
    check_val("first_pair", {mac_a, mac_b}, {ja[0], jb[0]});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    load_68();
    run_job(3, 0, 0, 0);
    run_job(3, 0, 2, 0);
    run_job(0, 0, 0, 0);
    ja[0] = 16'hFFFF; jb[0] = 16'hFFFF;
    ja[1] = 16'hFFFF; jb[1] = 16'hFFFF;
    run_job(2, 0, 0, 0);
    check_val("wide_result", result, 64'h1_FFFC_0002);
    load_68();
    run_job(3, 30, 0, 1);

`ifdef MAC_SEQ_ABORT_EN
    start_one_pair();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_ready", in_ready, 0);
    check_val("abort_clr", mac_clr, 1);
    check_val("abort_mac_ab", {mac_a, mac_b}, 0);
    check_val("abort_result", result, 68);
    check_val("abort_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      check_val("abort_no_done", done, 0);
    end
    check_val("abort_clr_single", mac_clr, 0);
    load_68();
    run_job(3, 0, 0, 0);
`endif

    for (int j = 0; j < 40; j++) begin
      int n;
      n = (j == 7) ? 255 : $urandom_range(0, 20);
      for (int i = 0; i < n; i++) begin
        ja[i] = rand_op();
        jb[i] = rand_op();
      end
      run_job(n, $urandom_range(0, 40), 0, 1);
    end

    start_one_pair();
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) begin
      @(negedge clk);
      check_val("reset_held_done", done, 0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("post_reset_done", done, 0);
      check_val("post_reset_busy", busy, 0);
    end
    load_68();
    run_job(3, 20, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
